sram_access_arbiter: RTL

Sequences the single-port, multi-cycle external SRAM shared by the instruction-fetch stage and the memory stage of the ARM pipeline.
- Grants one requester at a time and holds the SRAM control, address and data lines for the configured access length.
- Returns read data with a one-cycle ready pulse.
- Generates the freeze signals that stall the fetch stage and the whole pipeline while an access is pending.

---
 rtl/sram_access_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: shares one multi-cycle SRAM between the fetch
// and memory stages, sequencing each access and freezing the pipeline.
module sram_access_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int WAIT_CYCLES     = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifReq,
  input  logic [31:0]                ifAddr,
  output logic [31:0]                ifData,
  output logic                       ifReady,
  input  logic                       memRead,
  input  logic                       memWrite,
  input  logic [31:0]                memAddr,
  input  logic [31:0]                memWriteData,
  output logic [31:0]                memReadData,
  output logic                       memReady,
  output logic                       freezeFetch,
  output logic                       freezePipe,
  output logic [SRAM_ADDR_WIDTH-1:0] sramAddr,
  output logic [31:0]                sramWriteData,
  input  logic [31:0]                sramReadData,
  output logic                       sramWe,
  output logic                       sramOe
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IF   = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  logic [1:0]                 r_state;
  logic [1:0]                 w_next;
  logic [3:0]                 r_cnt;
  logic                       r_is_mem;
  logic                       r_is_wr;
  logic [SRAM_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                r_wdata;
  logic [31:0]                r_if_data;
  logic [31:0]                r_mem_data;

  logic                       w_mem_req;
  logic                       w_grant;
  logic                       w_in_acc;
  logic                       w_last;
  logic                       w_done;
  logic [SRAM_ADDR_WIDTH-1:0] w_grant_addr;
  logic                       w_unused_bits;

  assign w_mem_req = memRead | memWrite;
  assign w_grant   = (r_state == S_IDLE) & (w_mem_req | ifReq);
  assign w_in_acc  = (r_state == S_IF) | (r_state == S_MEM);
  assign w_last    = w_in_acc & (r_cnt == 4'd0);
  assign w_done    = (r_state == S_DONE);

  // Memory stage holds the older instruction, so its address wins.
  assign w_grant_addr = w_mem_req ?
    memAddr[SRAM_ADDR_WIDTH+1:2] :
    ifAddr[SRAM_ADDR_WIDTH+1:2];

  assign w_unused_bits = ^{ifAddr[31:SRAM_ADDR_WIDTH+2],
                           ifAddr[1:0],
                           memAddr[31:SRAM_ADDR_WIDTH+2],
                           memAddr[1:0]};

  // Next-state selection: arbitrate in IDLE, count out the access.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_mem_req) begin
          w_next = S_MEM;
        end else if (ifReq) begin
          w_next = S_IF;
        end
      end
      S_IF, S_MEM: begin
        if (r_cnt == 4'd0) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; async reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the granted request and run the wait-state down-counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_is_mem <= 1'b0;
      r_is_wr  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else if (w_grant) begin
      r_cnt    <= LP_WAIT;
      r_is_mem <= w_mem_req;
      r_is_wr  <= memWrite;
      r_addr   <= w_grant_addr;
      r_wdata  <= memWriteData;
    end else if (w_in_acc && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Capture read data on the last access cycle, per requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_if_data  <= 32'd0;
      r_mem_data <= 32'd0;
    end else if (w_last && !r_is_wr) begin
      if (r_is_mem) begin
        r_mem_data <= sramReadData;
      end else begin
        r_if_data <= sramReadData;
      end
    end
  end

  assign sramAddr      = r_addr;
  assign sramWriteData = r_wdata;
  assign sramWe        = w_in_acc & r_is_wr;
  assign sramOe        = w_in_acc & ~r_is_wr;

  assign ifReady     = w_done & ~r_is_mem;
  assign memReady    = w_done & r_is_mem;
  assign ifData      = r_if_data;
  assign memReadData = r_mem_data;

  assign freezePipe  = w_mem_req & ~memReady;
  assign freezeFetch = freezePipe | (ifReq & ~ifReady);

endmodule
